// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the TX/RX byte handshake between host logic and the responder
interface spi_slave_if #(parameter int WIDTH = 8);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;
  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI mode-0 responder with one-deep TX holding register
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_q;
  logic                   sclk_hist_q, cs_hist_q, mosi_hist_q, armed_q;
  logic                   sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;
  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       hold_q, hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d, miso_q, miso_d, load, wr;

  // Synchronise pins and register edge events; cs_fall needs a genuinely observed high cs first,
  // so a cs held low across reset cannot start a frame from the reset values of the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      mosi_hist_q <= 1'b0;
      armed_q     <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      mosi_hist_q <= mosi_sync_q[SYNC_STAGES-1];
      armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-1]);
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q;
      cs_fall_q   <= armed_q & ~cs_sync_q[SYNC_STAGES-1] & cs_hist_q;
      cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_hist_q;
    end
  end

  // Frame FSM, shift registers and holding register; a load always sees the pre-write holding state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    load      = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall_q) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        load    = 1'b1;
      end
    end else if (cs_rise_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sclk_rise_q) begin
      rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_hist_q};
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d      = '0;
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
        load       = 1'b1;
      end
    end else if (sclk_fall_q && cnt_q != '0) begin
      tx_sh_d = tx_sh_q << 1;
    end
    wr          = bus.tx_valid & ~hold_full_q;
    tx_sh_d     = load ? (hold_full_q ? hold_q : '0) : tx_sh_d;
    underrun_d  = load & ~hold_full_q;
    hold_full_d = wr | (hold_full_q & ~load);
    hold_d      = wr ? bus.tx_data : hold_q;
    miso_d      = (state_d == ACTIVE) & tx_sh_d[WIDTH-1];
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with hand-computed expectations for spi_slave
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.WIDTH(8)) bus();
  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int rxv0, und0;
  logic [7:0] rx_q[$];
  logic [7:0] got, got2;

  // Log rx_valid pulses and underrun pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) begin
        rx_q.push_back(bus.rx_data);
        rxv_cnt++;
      end
      if (bus.tx_underrun) und_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [7:0] got_v, input logic [7:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    chk("tx_ready_before_write", 8'(bus.tx_ready), 8'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] o, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.mosi = o[i];
      ticks(8);
      bus.sclk = 1'b1;
      r[i] = bus.miso;
      ticks(8);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic snap();
    rxv0 = rxv_cnt;
    und0 = und_cnt;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, 8'(bus.miso), 8'd0);
    chk({tag, "_tx_ready"}, 8'(bus.tx_ready), 8'd1);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_rx_valid"}, 8'(bus.rx_valid), 8'd0);
    chk({tag, "_underrun"}, 8'(bus.tx_underrun), 8'd0);
    chk({tag, "_busy"}, 8'(bus.busy), 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    chk_reset_vals("reset");

    wr(8'hA5);
    ticks(1);
    chk("single_ready_low", 8'(bus.tx_ready), 8'd0);
    snap();
    bus.cs = 1'b0;
    ticks(8);
    chk("single_busy_high", 8'(bus.busy), 8'd1);
    chk("single_no_underrun_at_start", 8'(und_cnt - und0), 8'd0);
    chk("single_ready_after_load", 8'(bus.tx_ready), 8'd1);
    xfer(8'h3C, 8, got);
    chk("single_miso", got, 8'hA5);
    bus.cs = 1'b1;
    ticks(8);
    chk("single_busy_low", 8'(bus.busy), 8'd0);
    chk("single_rx_data", bus.rx_data, 8'h3C);
    chk("single_rx_pulses", 8'(rxv_cnt - rxv0), 8'd1);
    chk("single_rx_logged", rx_q[rx_q.size()-1], 8'h3C);
    chk("single_trailing_underrun", 8'(und_cnt - und0), 8'd1);

    wr(8'h81);
    snap();
    bus.cs = 1'b0;
    ticks(8);
    wr(8'h7E);
    xfer(8'h11, 8, got);
    chk("b2b_no_underrun", 8'(und_cnt - und0), 8'd0);
    xfer(8'h22, 8, got2);
    bus.cs = 1'b1;
    ticks(8);
    chk("b2b_miso0", got, 8'h81);
    chk("b2b_miso1", got2, 8'h7E);
    chk("b2b_rx_pulses", 8'(rxv_cnt - rxv0), 8'd2);
    chk("b2b_rx0", rx_q[rx_q.size()-2], 8'h11);
    chk("b2b_rx1", rx_q[rx_q.size()-1], 8'h22);
    chk("b2b_trailing_underrun", 8'(und_cnt - und0), 8'd1);

    snap();
    bus.cs = 1'b0;
    ticks(8);
    chk("underrun_at_cs_fall", 8'(und_cnt - und0), 8'd1);
    xfer(8'hFF, 8, got);
    bus.cs = 1'b1;
    ticks(8);
    chk("underrun_miso", got, 8'h00);
    chk("underrun_rx_data", bus.rx_data, 8'hFF);
    chk("underrun_rx_pulses", 8'(rxv_cnt - rxv0), 8'd1);

    snap();
    bus.cs = 1'b0;
    ticks(8);
    xfer(8'h5A, 5, got);
    bus.cs = 1'b1;
    ticks(8);
    chk("abort_busy_low", 8'(bus.busy), 8'd0);
    chk("abort_no_rx", 8'(rxv_cnt - rxv0), 8'd0);
    chk("abort_rx_held", bus.rx_data, 8'hFF);
    snap();
    bus.cs = 1'b0;
    ticks(8);
    xfer(8'hC3, 8, got);
    bus.cs = 1'b1;
    ticks(8);
    chk("abort_next_rx", bus.rx_data, 8'hC3);
    chk("abort_next_pulses", 8'(rxv_cnt - rxv0), 8'd1);

    wr(8'hF0);
    bus.cs = 1'b0;
    ticks(8);
    xfer(8'hE7, 3, got);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    chk_reset_vals("midrst");
    snap();
    ticks(8);
    chk("midrst_idle", 8'(bus.busy), 8'd0);
    xfer(8'hAA, 8, got);
    chk("midrst_sclk_ignored_busy", 8'(bus.busy), 8'd0);
    chk("midrst_sclk_ignored_rx", 8'(rxv_cnt - rxv0), 8'd0);
    chk("midrst_miso_quiet", got, 8'h00);
    chk("midrst_rx_data", bus.rx_data, 8'h00);
    bus.cs = 1'b1;
    ticks(8);
    bus.cs = 1'b0;
    ticks(8);
    chk("midrst_fresh_busy", 8'(bus.busy), 8'd1);
    chk("midrst_fresh_underrun", 8'(und_cnt - und0), 8'd1);
    xfer(8'h5A, 8, got);
    bus.cs = 1'b1;
    ticks(8);
    chk("midrst_fresh_miso", got, 8'h00);
    chk("midrst_fresh_rx", bus.rx_data, 8'h5A);

    snap();
    bus.cs = 1'b0;
    ticks(3);
    bus.tx_data = 8'h99;
    bus.tx_valid = 1'b1;
    ticks(1);
    bus.tx_valid = 1'b0;
    ticks(4);
    chk("collide_underrun", 8'(und_cnt - und0), 8'd1);
    chk("collide_write_held", 8'(bus.tx_ready), 8'd0);
    xfer(8'h12, 8, got);
    xfer(8'h34, 8, got2);
    bus.cs = 1'b1;
    ticks(8);
    chk("collide_first_byte", got, 8'h00);
    chk("collide_second_byte", got2, 8'h99);
    chk("collide_rx", bus.rx_data, 8'h34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
